// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory bus between instruction fetch and the MEM stage.
// Bus cycles complete on bus_ack or are aborted by a watchdog. Returned data is held until pipe_adv.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ce,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   input  logic        mem_ce,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_sel,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   input  logic        pipe_adv,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        if_done, mem_done;
   logic [7:0]  cnt;
   logic        grant_mem, grant_if, timed_out, finish;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // MEM wins a simultaneous request: it belongs to the older instruction.
   always_comb begin
      state_nxt = state;
      grant_mem = 1'b0;
      grant_if  = 1'b0;
      timed_out = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_ce && !mem_done) begin
               grant_mem = 1'b1;
               state_nxt = BUS_MEM;
            end else if (if_ce && !if_done) begin
               grant_if  = 1'b1;
               state_nxt = BUS_IF;
            end
         end
         BUS_IF, BUS_MEM: begin
            timed_out = !bus_ack && (cnt == CNT_LAST);
            finish    = bus_ack || timed_out;
            if (finish) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_sel   <= '0;
         bus_wdata <= '0;
         if_rdata  <= '0;
         mem_rdata <= '0;
         if_done   <= 1'b0;
         mem_done  <= 1'b0;
         cnt       <= '0;
         bus_err   <= 1'b0;
      end else begin
         if (grant_mem) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_sel   <= mem_sel;
            bus_wdata <= mem_wdata;
         end else if (grant_if) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_sel   <= 4'hF;
            bus_wdata <= '0;
         end else if (finish) begin
            bus_req   <= 1'b0;
         end

         if (state == IDLE || finish) cnt <= '0;
         else if (cnt != 8'hFF)       cnt <= cnt + 8'd1;

         if (timed_out) bus_err <= 1'b1;

         // A completion on the same edge as pipe_adv must survive, so it is written last.
         if (pipe_adv) begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
         end
         if (finish && state == BUS_IF) begin
            if_done  <= 1'b1;
            if_rdata <= timed_out ? 32'd0 : bus_rdata;
         end
         if (finish && state == BUS_MEM) begin
            mem_done <= 1'b1;
            if (timed_out)    mem_rdata <= '0;
            else if (!bus_we) mem_rdata <= bus_rdata;
         end
      end
   end

   assign stall_mem = mem_ce && !mem_done;
   assign stall_if  = if_ce && !if_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a per-cycle vector table for the basic
// transactions plus hand sequences for watchdog abort and mid-cycle reset.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_ce, mem_ce, mem_we, pipe_adv, bus_ack;
   logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
   logic [3:0]  mem_sel;
   logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
   logic [3:0]  bus_sel;
   logic        stall_if, stall_mem, bus_req, bus_we, bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .if_ce(if_ce), .if_addr(if_addr), .if_rdata(if_rdata),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .pipe_adv(pipe_adv), .stall_if(stall_if), .stall_mem(stall_mem),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
   );

   typedef struct {
      logic        if_ce, mem_ce, mem_we;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic        pipe_adv, ack;
      logic [31:0] rdata;
      logic        e_sif, e_smem, e_req, e_we;
      logic [31:0] e_addr;
      logic [3:0]  e_sel;
      logic [31:0] e_wdata, e_ifr, e_memr;
      logic        e_err;
   } vec_t;

   function automatic vec_t mk(
      input logic ic, mc, mw, input logic [3:0] s, input logic [31:0] wd,
      input logic pa, ak, input logic [31:0] rd,
      input logic esi, esm, erq, ewe, input logic [31:0] ead, input logic [3:0] esl,
      input logic [31:0] ewd, eir, emr, input logic eer);
      vec_t v;
      v.if_ce = ic; v.mem_ce = mc; v.mem_we = mw; v.sel = s; v.wdata = wd;
      v.pipe_adv = pa; v.ack = ak; v.rdata = rd;
      v.e_sif = esi; v.e_smem = esm; v.e_req = erq; v.e_we = ewe; v.e_addr = ead;
      v.e_sel = esl; v.e_wdata = ewd; v.e_ifr = eir; v.e_memr = emr; v.e_err = eer;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ic, mc, mw, input logic [3:0] s, input logic [31:0] wd,
                        input logic pa, ak, input logic [31:0] rd);
      if_ce = ic; mem_ce = mc; mem_we = mw; mem_sel = s; mem_wdata = wd;
      pipe_adv = pa; bus_ack = ak; bus_rdata = rd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl[19];

   initial begin
      // Fetch, contended MEM-then-IF, store, and pipe_adv coinciding with ack.
      tbl[0]  = mk(1,0,0,4'hF,0,0,0,0,                   1,0,0,0,32'h0,   4'h0,0,      0,            0,            0);
      tbl[1]  = mk(1,0,0,4'hF,0,0,1,32'h3C010001,        1,0,1,0,32'h100, 4'hF,0,      0,            0,            0);
      tbl[2]  = mk(1,0,0,4'hF,0,1,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'h3C010001, 0,            0);
      tbl[3]  = mk(0,0,0,4'hF,0,0,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'h3C010001, 0,            0);
      tbl[4]  = mk(1,1,0,4'hF,0,0,0,0,                   1,1,0,0,32'h100, 4'hF,0,      32'h3C010001, 0,            0);
      tbl[5]  = mk(1,1,0,4'hF,0,0,1,32'h11112222,        1,1,1,0,32'h2000,4'hF,0,      32'h3C010001, 0,            0);
      tbl[6]  = mk(1,1,0,4'hF,0,0,0,0,                   1,0,0,0,32'h2000,4'hF,0,      32'h3C010001, 32'h11112222, 0);
      tbl[7]  = mk(1,1,0,4'hF,0,0,1,32'hAAAA5555,        1,0,1,0,32'h100, 4'hF,0,      32'h3C010001, 32'h11112222, 0);
      tbl[8]  = mk(1,1,0,4'hF,0,1,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'hAAAA5555, 32'h11112222, 0);
      tbl[9]  = mk(0,0,0,4'hF,0,0,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'hAAAA5555, 32'h11112222, 0);
      tbl[10] = mk(0,1,1,4'h3,32'hBEEF,0,0,0,            0,1,0,0,32'h100, 4'hF,0,      32'hAAAA5555, 32'h11112222, 0);
      tbl[11] = mk(0,1,1,4'h3,32'hBEEF,0,1,32'hDEADDEAD, 0,1,1,1,32'h2000,4'h3,32'hBEEF,32'hAAAA5555, 32'h11112222, 0);
      tbl[12] = mk(0,1,1,4'h3,32'hBEEF,1,0,0,            0,0,0,1,32'h2000,4'h3,32'hBEEF,32'hAAAA5555, 32'h11112222, 0);
      tbl[13] = mk(0,0,0,4'hF,0,0,0,0,                   0,0,0,1,32'h2000,4'h3,32'hBEEF,32'hAAAA5555, 32'h11112222, 0);
      tbl[14] = mk(1,0,0,4'hF,0,0,0,0,                   1,0,0,1,32'h2000,4'h3,32'hBEEF,32'hAAAA5555, 32'h11112222, 0);
      tbl[15] = mk(1,0,0,4'hF,0,1,1,32'h12345678,        1,0,1,0,32'h100, 4'hF,0,      32'hAAAA5555, 32'h11112222, 0);
      tbl[16] = mk(1,0,0,4'hF,0,0,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'h12345678, 32'h11112222, 0);
      tbl[17] = mk(1,0,0,4'hF,0,1,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'h12345678, 32'h11112222, 0);
      tbl[18] = mk(0,0,0,4'hF,0,0,0,0,                   0,0,0,0,32'h100, 4'hF,0,      32'h12345678, 32'h11112222, 0);

      rst = 1'b1;
      if_addr = 32'h100;
      mem_addr = 32'h2000;
      drive(0,0,0,4'h0,0,0,0,0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.bus_req",   {31'd0, bus_req},   0);
      chk("reset.bus_we",    {31'd0, bus_we},    0);
      chk("reset.bus_addr",  bus_addr,           0);
      chk("reset.bus_sel",   {28'd0, bus_sel},   0);
      chk("reset.bus_wdata", bus_wdata,          0);
      chk("reset.if_rdata",  if_rdata,           0);
      chk("reset.mem_rdata", mem_rdata,          0);
      chk("reset.bus_err",   {31'd0, bus_err},   0);
      chk("reset.stall_if",  {31'd0, stall_if},  0);
      chk("reset.stall_mem", {31'd0, stall_mem}, 0);
      rst = 1'b0;

      for (int i = 0; i < 19; i++) begin
         next_cycle();
         drive(tbl[i].if_ce, tbl[i].mem_ce, tbl[i].mem_we, tbl[i].sel, tbl[i].wdata,
               tbl[i].pipe_adv, tbl[i].ack, tbl[i].rdata);
         @(negedge clk);
         chk($sformatf("r%0d.stall_if", i),  {31'd0, stall_if},  {31'd0, tbl[i].e_sif});
         chk($sformatf("r%0d.stall_mem", i), {31'd0, stall_mem}, {31'd0, tbl[i].e_smem});
         chk($sformatf("r%0d.bus_req", i),   {31'd0, bus_req},   {31'd0, tbl[i].e_req});
         chk($sformatf("r%0d.bus_we", i),    {31'd0, bus_we},    {31'd0, tbl[i].e_we});
         chk($sformatf("r%0d.bus_addr", i),  bus_addr,           tbl[i].e_addr);
         chk($sformatf("r%0d.bus_sel", i),   {28'd0, bus_sel},   {28'd0, tbl[i].e_sel});
         chk($sformatf("r%0d.bus_wdata", i), bus_wdata,          tbl[i].e_wdata);
         chk($sformatf("r%0d.if_rdata", i),  if_rdata,           tbl[i].e_ifr);
         chk($sformatf("r%0d.mem_rdata", i), mem_rdata,          tbl[i].e_memr);
         chk($sformatf("r%0d.bus_err", i),   {31'd0, bus_err},   {31'd0, tbl[i].e_err});
      end

      // Watchdog: load never acknowledged, abort after exactly 4 bus_req cycles.
      next_cycle();
      drive(0,1,0,4'hF,0,0,0,0);
      @(negedge clk);
      chk("to.grant_stall", {31'd0, stall_mem}, 1);
      chk("to.grant_req",   {31'd0, bus_req},   0);
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         @(negedge clk);
         chk($sformatf("to.busy%0d.req", k), {31'd0, bus_req},   1);
         chk($sformatf("to.busy%0d.err", k), {31'd0, bus_err},   0);
         chk($sformatf("to.busy%0d.stall", k), {31'd0, stall_mem}, 1);
      end
      next_cycle();
      drive(0,1,0,4'hF,0,1,0,0);
      @(negedge clk);
      chk("to.abort.req",       {31'd0, bus_req},   0);
      chk("to.abort.stall_mem", {31'd0, stall_mem}, 0);
      chk("to.abort.mem_rdata", mem_rdata,          0);
      chk("to.abort.bus_err",   {31'd0, bus_err},   1);
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         drive(0,0,0,4'hF,0,0,0,0);
         @(negedge clk);
         chk($sformatf("to.sticky%0d.err", k), {31'd0, bus_err}, 1);
         chk($sformatf("to.sticky%0d.req", k), {31'd0, bus_req}, 0);
      end

      // Reset arriving while a fetch is on the bus.
      next_cycle();
      drive(1,0,0,4'hF,0,0,0,0);
      @(negedge clk);
      chk("rst.pre_stall", {31'd0, stall_if}, 1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rst.busy_req", {31'd0, bus_req}, 1);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst.req",       {31'd0, bus_req},  0);
      chk("rst.stall_if",  {31'd0, stall_if}, 1);
      chk("rst.if_rdata",  if_rdata,          0);
      chk("rst.mem_rdata", mem_rdata,         0);
      chk("rst.bus_err",   {31'd0, bus_err},  0);
      chk("rst.bus_addr",  bus_addr,          0);
      chk("rst.bus_sel",   {28'd0, bus_sel},  0);
      next_cycle();
      drive(1,0,0,4'hF,0,0,1,32'h00000055);
      @(negedge clk);
      chk("rst.regrant_req",  {31'd0, bus_req}, 1);
      chk("rst.regrant_addr", bus_addr,         32'h100);
      next_cycle();
      drive(0,0,0,4'hF,0,0,0,0);
      @(negedge clk);
      chk("rst.refetch_data", if_rdata,         32'h00000055);
      chk("rst.refetch_req",  {31'd0, bus_req}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
